// File: rtl/fb_pkg.sv
// Framebuffer geometry, palette entries and the write-arbiter state encoding
// shared by the pixel writers and the framebuffer write path.
package fb_pkg;

    localparam int SCREEN_W = 176;
    localparam int SCREEN_H = 120;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

    localparam logic [2:0] COLOR_SCREEN = 3'b101;
    localparam logic [2:0] COLOR_OBJECT = 3'b111;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request above ptr, wrapping,
// returned as a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    logic [PW-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the single framebuffer write port between pixel writers round-robin
// and fills the screen with the background colour after reset or on request.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int              AW          = 15,
    parameter int              DW          = 3,
    parameter int              NREQ        = 4,
    parameter int              SCREEN_W    = 176,
    parameter int              SCREEN_H    = 120,
    parameter logic [DW-1:0]   CLEAR_COLOR = COLOR_SCREEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_start,
    output logic                 clr_busy,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        mem_px_addr,
    output logic [DW-1:0]        mem_px_data,
    output logic                 px_wr,
    output logic                 oob_err
);

    localparam int            PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            DEPTH     = SCREEN_W * SCREEN_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);

    fb_state_e      state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           wr_q, wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           oob_q, oob_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_addr = req_addr[i*AW +: AW];
                g_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        oob_d     = 1'b0;
        req_ready = '0;
        unique case (state_q)
            CLEAR: begin
                wr_d   = 1'b1;
                addr_d = cnt_q;
                data_d = CLEAR_COLOR;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB: begin
                req_ready = gnt;
                if (|gnt) begin
                    ptr_d = gnt_idx;
                    // Off-screen writes are consumed but never reach memory.
                    if ({1'b0, g_addr} < DEPTH_X) begin
                        wr_d   = 1'b1;
                        addr_d = g_addr;
                        data_d = g_data;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            oob_q   <= oob_d;
        end
    end

    assign clr_busy    = (state_q == CLEAR);
    assign px_wr       = wr_q;
    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign oob_err     = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table for arbitration plus
// sequences for full clears, clear-on-command and reset in mid-fill.
module tb_fb_write_arbiter;

    localparam int DEPTH = 21120;
    localparam logic [3:0][14:0] DEF_A = {15'd20000, 15'd7777, 15'd2000, 15'd100};
    localparam logic [3:0][2:0]  DEF_D = {3'd4, 3'd6, 3'd2, 3'd1};

    logic        clk;
    logic        rst;
    logic        clr_start;
    logic        clr_busy;
    logic [3:0]  req_valid;
    logic [59:0] req_addr;
    logic [11:0] req_data;
    logic [3:0]  req_ready;
    logic [14:0] mem_px_addr;
    logic [2:0]  mem_px_data;
    logic        px_wr;
    logic        oob_err;

    fb_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .oob_err     (oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] a;
        logic [2:0]  d;
    } wr_t;

    typedef struct {
        logic [3:0]       vld;
        logic [3:0][14:0] a;
        logic [3:0][2:0]  d;
        logic [3:0]       rdy;
        logic             wr;
        logic             oob;
        logic [14:0]      wa;
        logic [2:0]       wd;
    } vec_t;

    wr_t  sb[$];
    vec_t tbl[$];
    wr_t  mon_w;
    int   n_pass;
    int   n_total;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic push_wr(input logic [14:0] a, input logic [2:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        sb.push_back(w);
    endtask

    task automatic push_fill(input int upto);
        for (int k = 0; k < upto; k++) push_wr(15'(k), 3'd5);
    endtask

    task automatic add(input logic [3:0] vld, input logic pen, input logic [1:0] pi,
                       input logic [14:0] pa, input logic [2:0] pd,
                       input logic [3:0] rdy, input logic wr, input logic oob,
                       input logic [14:0] wa, input logic [2:0] wd);
        vec_t v;
        v.vld = vld;
        v.a   = DEF_A;
        v.d   = DEF_D;
        if (pen) begin
            v.a[pi] = pa;
            v.d[pi] = pd;
        end
        v.rdy = rdy;
        v.wr  = wr;
        v.oob = oob;
        v.wa  = wa;
        v.wd  = wd;
        tbl.push_back(v);
    endtask

    // Runs until clr_busy falls (bounded); counts edges and any nonzero ready.
    task automatic wait_clear(output int n, output int bad_rdy, input int pulse_at);
        n = 0;
        bad_rdy = 0;
        while (clr_busy && n < 25000) begin
            if (req_ready !== 4'b0000) bad_rdy++;
            @(posedge clk);
            #1;
            n++;
            clr_start = (n == pulse_at);
        end
        clr_start = 1'b0;
    endtask

    // Every registered write must match the next expected entry, in order.
    always @(negedge clk) begin
        if (px_wr === 1'b1) begin
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_w = sb.pop_front();
                chk("write_addr_data", 32'({mem_px_addr, mem_px_data}), 32'({mon_w.a, mon_w.d}));
            end
        end
    end

    initial begin
        int n;
        int bad;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        clr_start = 1'b0;
        req_valid = 4'b1111;
        req_addr  = DEF_A;
        req_data  = DEF_D;

        add(4'b1111, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0001, 1'b1, 1'b0, 15'd100,   3'd1);
        add(4'b1111, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0010, 1'b1, 1'b0, 15'd2000,  3'd2);
        add(4'b1111, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0100, 1'b1, 1'b0, 15'd7777,  3'd6);
        add(4'b1111, 1'b0, 2'd0, 15'd0,     3'd0, 4'b1000, 1'b1, 1'b0, 15'd20000, 3'd4);
        add(4'b1111, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0001, 1'b1, 1'b0, 15'd100,   3'd1);
        add(4'b0100, 1'b1, 2'd2, 15'd15900, 3'd7, 4'b0100, 1'b1, 1'b0, 15'd15900, 3'd7);
        add(4'b0000, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0000, 1'b0, 1'b0, 15'd0,     3'd0);
        add(4'b0010, 1'b1, 2'd1, 15'd21120, 3'd2, 4'b0010, 1'b0, 1'b1, 15'd0,     3'd0);
        add(4'b0101, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0100, 1'b1, 1'b0, 15'd7777,  3'd6);
        add(4'b0011, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0001, 1'b1, 1'b0, 15'd100,   3'd1);
        add(4'b0011, 1'b0, 2'd0, 15'd0,     3'd0, 4'b0010, 1'b1, 1'b0, 15'd2000,  3'd2);
        add(4'b1010, 1'b1, 2'd3, 15'd21119, 3'd4, 4'b1000, 1'b1, 1'b0, 15'd21119, 3'd4);
        add(4'b1000, 1'b1, 2'd3, 15'd32767, 3'd4, 4'b1000, 1'b0, 1'b1, 15'd0,     3'd0);

        // Reset state, with every client already requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_px_wr",    32'(px_wr),       32'd0);
        chk("rst_addr",     32'(mem_px_addr), 32'd0);
        chk("rst_data",     32'(mem_px_data), 32'd0);
        chk("rst_oob",      32'(oob_err),     32'd0);
        chk("rst_clr_busy", 32'(clr_busy),    32'd1);
        chk("rst_ready",    32'(req_ready),   32'd0);

        // Power-on fill.
        push_fill(DEPTH);
        rst = 1'b0;
        wait_clear(n, bad, -1);
        chk("clear1_cycles", 32'(n),   32'(DEPTH));
        chk("clear1_ready",  32'(bad), 32'd0);

        // Arbitration vectors: ready same cycle, write/oob one cycle later.
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            req_valid = v.vld;
            req_addr  = v.a;
            req_data  = v.d;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(v.rdy));
            if (v.wr) push_wr(v.wa, v.wd);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_px_wr", i), 32'(px_wr),   32'(v.wr));
            chk($sformatf("tbl%0d_oob", i),   32'(oob_err), 32'(v.oob));
            if (v.wr)
                chk($sformatf("tbl%0d_wr", i), 32'({mem_px_addr, mem_px_data}), 32'({v.wa, v.wd}));
        end

        // clr_start with a same-cycle grant to client 0; client 3 waits out the fill.
        req_valid = 4'b1001;
        req_addr  = {15'd444, 15'd0, 15'd0, 15'd333};
        req_data  = {3'd3, 3'd0, 3'd0, 3'd2};
        clr_start = 1'b1;
        #1;
        chk("cs_ready", 32'(req_ready), 32'h1);
        push_wr(15'd333, 3'd2);
        push_fill(DEPTH);
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        req_valid = 4'b1000;
        chk("cs_grant_wr", 32'({px_wr, mem_px_addr, mem_px_data}), 32'({1'b1, 15'd333, 3'd2}));
        chk("cs_clr_busy", 32'(clr_busy), 32'd1);
        @(posedge clk);
        #1;
        chk("cs_first_fill", 32'({px_wr, mem_px_addr}), 32'({1'b1, 15'd0}));
        wait_clear(n, bad, -1);
        chk("clear2_cycles", 32'(n),         32'(DEPTH - 1));
        chk("clear2_ready",  32'(bad),       32'd0);
        chk("held_c3_ready", 32'(req_ready), 32'h8);
        push_wr(15'd444, 3'd3);
        @(posedge clk);
        #1;
        chk("held_c3_wr", 32'({px_wr, mem_px_addr, mem_px_data}), 32'({1'b1, 15'd444, 3'd3}));
        req_addr  = DEF_A;
        req_data  = DEF_D;
        req_valid = 4'b0010;
        #1;
        chk("c1_ready", 32'(req_ready), 32'h2);
        push_wr(15'd2000, 3'd2);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;

        // Reset when the fill is about to write address 5000.
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        push_fill(5000);
        repeat (5000) @(posedge clk);
        #1;
        chk("mid_last_addr", 32'({px_wr, mem_px_addr}), 32'({1'b1, 15'd4999}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_px_wr", 32'(px_wr),       32'd0);
        chk("mid_rst_addr",  32'(mem_px_addr), 32'd0);
        chk("mid_rst_busy",  32'(clr_busy),    32'd1);
        chk("mid_sb_empty",  32'(sb.size()),   32'd0);
        rst = 1'b0;
        req_valid = 4'b1111;
        push_fill(DEPTH);
        wait_clear(n, bad, 100);
        chk("clear3_cycles", 32'(n),         32'(DEPTH));
        chk("clear3_ready",  32'(bad),       32'd0);
        chk("ptr_after_rst", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_px_wr",    32'(px_wr),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
